// File: rtl/hamming_secded_serial_encoder.sv
// SECDED (72,64) encoder that serialises each codeword MSB first with a one-cycle gap.
// Optional error injection when ENC_INJECT_EN is defined: loaded codeword is XORed with inject_mask.
module hamming_secded_serial_encoder #(
  parameter int FRAME_BITS = 72,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [FRAME_BITS-1:0] inject_mask,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic                  busy,
  output logic [CNT_W-1:0]      frames_sent
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  localparam logic [6:0] LastBit = 7'(FRAME_BITS - 1);

  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [6:0]              bit_cnt_q;
  logic                    serial_out_q;
  logic                    serial_valid_q;
  logic                    frame_start_q;
  logic                    busy_q;
  logic [CNT_W-1:0]        frames_sent_q;
  logic [FRAME_BITS-1:0]   cw;
  logic [FRAME_BITS-1:0]   cw_tx;

  // Data bit k sits at the k-th non-power-of-two position from 3 upward; each set position
  // bit contributes that data bit to the matching check bit.
  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [6:0] c;
    logic [6:0] p7;
    logic [5:0] k;
    c = '0;
    k = '0;
    for (int pos = 3; pos < 72; pos++) begin
      p7 = 7'(pos);
      if ((p7 & (p7 - 7'd1)) != 7'd0) begin
        c = c ^ (p7 & {7{d[k]}});
        k = k + 6'd1;
      end
    end
    return {d, c, ^{d, c}};
  endfunction

  always_comb begin
    cw = encode(data_in);
`ifdef ENC_INJECT_EN
    cw_tx = cw ^ inject_mask;
`else
    cw_tx = cw;
`endif
  end

`ifndef ENC_INJECT_EN
  logic unused_inject_mask;
  assign unused_inject_mask = ^inject_mask;
`endif

  assign data_ready   = !reset && (state_q != StShift);
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign busy         = busy_q;
  assign frames_sent  = frames_sent_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      busy_q         <= 1'b0;
      frames_sent_q  <= '0;
    end else begin
      frame_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StGap: begin
          if (data_valid) begin
            // Bit 71 goes straight to the output register; the rest queue up behind it.
            shift_q        <= {cw_tx[FRAME_BITS-2:0], 1'b0};
            serial_out_q   <= cw_tx[FRAME_BITS-1];
            serial_valid_q <= 1'b1;
            frame_start_q  <= 1'b1;
            busy_q         <= 1'b1;
            bit_cnt_q      <= '0;
            state_q        <= StShift;
          end else if (state_q == StGap) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StShift: begin
          if (bit_cnt_q == LastBit) begin
            state_q        <= StGap;
            bit_cnt_q      <= '0;
            frames_sent_q  <= frames_sent_q + 1'b1;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
          end else begin
            serial_out_q <= shift_q[FRAME_BITS-1];
            shift_q      <= {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q    <= bit_cnt_q + 7'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_secded_serial_encoder.sv
// Self-checking bench: table vectors, back-to-back stream, mid-frame reset, optional injection.
// Received frames are checked against a scoreboard and an independent SECDED decoder model.
module tb_hamming_secded_serial_encoder;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [63:0]      data_in = '0;
  logic             data_valid = 1'b0;
  logic             data_ready;
  logic [71:0]      inject_mask = '0;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;
  logic [CNT_W-1:0] frames_sent;

  hamming_secded_serial_encoder #(.FRAME_BITS(72), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .inject_mask  (inject_mask),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [71:0] cw;
    logic [63:0] data;
    logic        corr;
    logic        det;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  chk;
  } vec_t;

  exp_t        sb[$];
  int unsigned fs_cycles[$];
  logic [71:0] last_rx = '0;
  logic [71:0] rx = '0;
  int          nbits = 0;
  logic [6:0]  pos_of_k[64];
  int          idx_of_pos[72];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Check bits = syndrome of the data positions, so XOR the positions of the set data bits.
  function automatic logic [71:0] enc_model(input logic [63:0] d);
    logic [6:0] s;
    s = '0;
    for (int k = 0; k < 64; k++) if (d[k]) s = s ^ pos_of_k[k];
    return {d, s, ^{d, s}};
  endfunction

  function automatic void decode(input logic [71:0] r, output logic [63:0] d,
                                 output logic corr, output logic det);
    logic [6:0]  syn;
    logic [71:0] f;
    syn = '0;
    for (int pos = 1; pos < 72; pos++) if (r[idx_of_pos[pos]]) syn = syn ^ 7'(pos);
    f = r;
    corr = 1'b0;
    det = 1'b0;
    if (^r) begin
      corr = 1'b1;
      if (syn < 7'd72) f[idx_of_pos[syn]] = ~f[idx_of_pos[syn]];
    end else if (syn != 7'd0) begin
      det = 1'b1;
    end
    d = f[71:8];
  endfunction

  function automatic exp_t make_exp(input logic [63:0] d, input logic [71:0] m);
    exp_t e;
    e.data = d;
`ifdef ENC_INJECT_EN
    e.cw   = enc_model(d) ^ m;
    e.corr = ($countones(m) == 1);
    e.det  = ($countones(m) == 2);
`else
    e.cw   = enc_model(d);
    e.corr = 1'b0;
    e.det  = 1'b0;
    if (m == '1) e.corr = 1'b1;  // never true; keeps the mask argument referenced
`endif
    return e;
  endfunction

  // Monitor: reassemble frames, compare against the scoreboard and the decoder model.
  always @(negedge clk) begin
    if (reset) begin
      nbits = 0;
      sb.delete();
    end else if (serial_valid) begin
      if (frame_start) begin
        check("frame_start_aligned", 72'(nbits), 72'd0);
        nbits = 0;
        fs_cycles.push_back(cyc);
      end
      rx = {rx[70:0], serial_out};
      nbits++;
      if (nbits == 72) begin
        nbits = 0;
        last_rx = rx;
        if (sb.size() == 0) begin
          check("unexpected_frame", rx, 72'd0);
        end else begin
          exp_t        e;
          logic [63:0] dd;
          logic        c;
          logic        dt;
          e = sb.pop_front();
          check("codeword", rx, e.cw);
          decode(rx, dd, c, dt);
          check("dec_corrected", 72'(c), 72'(e.corr));
          check("dec_detected", 72'(dt), 72'(e.det));
          if (!e.det) check("dec_data", 72'(dd), 72'(e.data));
        end
      end
    end else begin
      check("idle_out_zero", 72'({serial_out, frame_start}), 72'd0);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 72'(busy), 72'd0);
    check("scoreboard_drained", 72'(sb.size()), 72'd0);
  endtask

  task automatic send_word(input logic [63:0] d, input logic [71:0] m);
    logic [CNT_W-1:0] base;
    int               t;
    @(negedge clk);
    base = frames_sent;
    data_in = d;
    inject_mask = m;
    data_valid = 1'b1;
    t = 0;
    while (!data_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", 72'(data_ready), 72'd1);
    @(posedge clk);
    sb.push_back(make_exp(d, m));
    @(negedge clk);
    data_valid = 1'b0;
    data_in = {$urandom, $urandom};
    check("first_bit_timing", 72'({frame_start, serial_valid, data_ready}), 72'b110);
    repeat (71) @(negedge clk);
    check("last_bit_timing", 72'({frame_start, serial_valid}), 72'b01);
    @(negedge clk);
    check("gap_cycle", 72'({serial_valid, busy, data_ready}), 72'b011);
    check("frames_sent_inc", 72'(frames_sent), 72'(base + 1'b1));
    wait_idle();
  endtask

  initial begin
    vec_t             vecs[5];
    logic [63:0]      w[3];
    logic [CNT_W-1:0] base;
    int               k;
    int               t;

    k = 0;
    idx_of_pos[0] = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        idx_of_pos[pos] = 1 + $clog2(pos);
      end else begin
        pos_of_k[k] = 7'(pos);
        idx_of_pos[pos] = 8 + k;
        k++;
      end
    end

    vecs[0] = '{64'h0, 8'h00};
    vecs[1] = '{64'h0000_0000_0000_0001, 8'h07};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
    vecs[3] = '{64'h8000_0000_0000_0000, 8'h8F};
    vecs[4] = '{64'h0000_0000_0000_0002, 8'h0B};

    repeat (3) @(negedge clk);
    check("reset_ready", 72'(data_ready), 72'd0);
    check("reset_outputs", 72'({serial_out, serial_valid, frame_start, busy}), 72'd0);
    check("reset_frames_sent", 72'(frames_sent), 72'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 72'(data_ready), 72'd1);

    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].data, '0);
      check("table_check_byte", 72'(last_rx[7:0]), 72'(vecs[i].chk));
      check("table_data_field", 72'(last_rx[71:8]), 72'(vecs[i].data));
    end
    check("frames_after_table", 72'(frames_sent), 72'd5);

    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, '0);

    // Three words with data_valid held high across frames.
    for (int i = 0; i < 3; i++) w[i] = {$urandom, $urandom};
    fs_cycles.delete();
    @(negedge clk);
    base = frames_sent;
    data_in = w[0];
    data_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (!data_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("b2b_ready_timeout", 72'(data_ready), 72'd1);
      @(posedge clk);
      sb.push_back(make_exp(w[j], '0));
      @(negedge clk);
      if (j < 2) data_in = w[j + 1];
      else data_valid = 1'b0;
    end
    wait_idle();
    check("b2b_frame_count", 72'(fs_cycles.size()), 72'd3);
    if (fs_cycles.size() == 3) begin
      check("b2b_period_0", 72'(fs_cycles[1] - fs_cycles[0]), 72'd73);
      check("b2b_period_1", 72'(fs_cycles[2] - fs_cycles[1]), 72'd73);
    end
    check("b2b_frames_sent", 72'(frames_sent), 72'(base + 3));

    // Mask ignored in the default build; single/double faults when injection is enabled.
    send_word(64'h0123_4567_89AB_CDEF, 72'h1 << 40);
    send_word(64'hFEDC_BA98_7654_3210, 72'h3 << 40);

    // Reset in the middle of a frame.
    @(negedge clk);
    data_in = 64'hDEAD_BEEF_CAFE_F00D;
    data_valid = 1'b1;
    @(posedge clk);
    sb.push_back(make_exp(data_in, '0));
    @(negedge clk);
    data_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_abort_valid", 72'(serial_valid), 72'd1);
    reset = 1'b1;
    #1;
    check("abort_outputs", 72'({serial_out, serial_valid, frame_start, busy, data_ready}), 72'd0);
    check("abort_frames_sent", 72'(frames_sent), 72'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_resume", 72'({serial_valid, busy}), 72'd0);
    send_word(64'h5555_AAAA_3333_CCCC, '0);
    check("post_abort_data", 72'(last_rx[71:8]), 72'(64'h5555_AAAA_3333_CCCC));
    check("post_abort_frames", 72'(frames_sent), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
